// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the execute stage.
// Multiplies use a shift-add over XLEN steps with a signed correction on the
// last step. Divides use restoring division on magnitudes with sign fix-up.
// Divide-by-zero and signed overflow complete in one cycle without iterating.
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_rdata,
  input  logic [XLEN-1:0] rs2_rdata,
  input  logic [4:0]      rd_waddr,
  output logic            hold_o,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_waddr_o
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

  // Registered state
  logic [1:0]        state_r;
  logic [CW-1:0]     cnt_r;
  logic [2:0]        op_r;
  logic [2*XLEN-1:0] acc_r;      // multiply: product; divide: {remainder, quotient}
  logic [2*XLEN-1:0] mcand_r;    // multiply: extended multiplicand, shifted left each step
  logic [XLEN-1:0]   mplier_r;   // multiply: multiplier bits; divide: divisor magnitude
  logic              neg_q_r;
  logic              neg_rem_r;
  logic [XLEN-1:0]   result_r;
  logic [4:0]        rd_r;

  // Combinational signals
  logic [1:0]        state_fsm_s;
  logic [1:0]        state_nxt_s;
  logic              last_s;
  logic              is_div_s;
  logic              div_signed_s;
  logic              div_zero_s;
  logic              div_ovf_s;
  logic              special_s;
  logic [XLEN-1:0]   special_res_s;
  logic              a_ext_signed_s;
  logic [2*XLEN-1:0] mcand_init_s;
  logic              a_neg_s;
  logic              b_neg_s;
  logic [XLEN-1:0]   mag_a_s;
  logic [XLEN-1:0]   mag_b_s;
  logic [2*XLEN-1:0] addend_s;
  logic [2*XLEN-1:0] mul_acc_s;
  logic [XLEN:0]     shifted_s;
  logic [XLEN:0]     diff_s;
  logic [2*XLEN-1:0] div_acc_s;
  logic [2*XLEN-1:0] acc_nxt_s;
  logic [XLEN-1:0]   lo_s;
  logic [XLEN-1:0]   hi_s;
  logic [XLEN-1:0]   final_s;

  assign last_s = (cnt_r == CW'(XLEN-1));

  // Decode the incoming request: special divides, operand extension, magnitudes
  always_comb begin
    is_div_s       = op[2];
    div_signed_s   = ~op[0];
    div_zero_s     = (rs2_rdata == {XLEN{1'b0}});
    div_ovf_s      = div_signed_s && (rs1_rdata == INT_MIN) && (rs2_rdata == ALL_ONE);
    special_s      = is_div_s && (div_zero_s || div_ovf_s);
    if (div_zero_s) begin
      special_res_s = op[1] ? rs1_rdata : ALL_ONE;
    end else begin
      special_res_s = op[1] ? {XLEN{1'b0}} : rs1_rdata;
    end
    a_ext_signed_s = (op == OP_MULH) || (op == OP_MULHSU);
    if (a_ext_signed_s) begin
      mcand_init_s = {{XLEN{rs1_rdata[XLEN-1]}}, rs1_rdata};
    end else begin
      mcand_init_s = {{XLEN{1'b0}}, rs1_rdata};
    end
    a_neg_s = div_signed_s && rs1_rdata[XLEN-1];
    b_neg_s = div_signed_s && rs2_rdata[XLEN-1];
    mag_a_s = a_neg_s ? ({XLEN{1'b0}} - rs1_rdata) : rs1_rdata;
    mag_b_s = b_neg_s ? ({XLEN{1'b0}} - rs2_rdata) : rs2_rdata;
  end

  // One radix-2 iteration for the operation in flight
  always_comb begin
    addend_s = mplier_r[0] ? mcand_r : {(2*XLEN){1'b0}};
    // Multiplier MSB carries negative weight when rs2 is signed (MULH only)
    if (last_s && (op_r == OP_MULH)) begin
      mul_acc_s = acc_r - addend_s;
    end else begin
      mul_acc_s = acc_r + addend_s;
    end
    shifted_s = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
    diff_s    = shifted_s - {1'b0, mplier_r};
    if (!diff_s[XLEN]) begin
      div_acc_s = {diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
    end else begin
      div_acc_s = {shifted_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
    end
    acc_nxt_s = op_r[2] ? div_acc_s : mul_acc_s;
  end

  // Select and sign-correct the final result from the last iteration
  always_comb begin
    lo_s = acc_nxt_s[XLEN-1:0];
    hi_s = acc_nxt_s[2*XLEN-1:XLEN];
    case (op_r)
      OP_MUL:                    final_s = lo_s;
      3'b001, 3'b010, 3'b011:    final_s = hi_s;
      3'b100, 3'b101:            final_s = neg_q_r ? ({XLEN{1'b0}} - lo_s) : lo_s;
      3'b110, 3'b111:            final_s = neg_rem_r ? ({XLEN{1'b0}} - hi_s) : hi_s;
      default:                   final_s = lo_s;
    endcase
  end

  // Next-state logic; flush always wins and returns to IDLE
  always_comb begin
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_fsm_s = special_s ? S_DONE : S_CALC;
        end else begin
          state_fsm_s = S_IDLE;
        end
      end
      S_CALC: begin
        if (last_s) begin
          state_fsm_s = S_DONE;
        end else begin
          state_fsm_s = S_CALC;
        end
      end
      S_DONE:  state_fsm_s = S_IDLE;
      default: state_fsm_s = S_IDLE;
    endcase
    state_nxt_s = flush ? S_IDLE : state_fsm_s;
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_IDLE;
      cnt_r     <= {CW{1'b0}};
      op_r      <= 3'b000;
      acc_r     <= {(2*XLEN){1'b0}};
      mcand_r   <= {(2*XLEN){1'b0}};
      mplier_r  <= {XLEN{1'b0}};
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
      result_r  <= {XLEN{1'b0}};
      rd_r      <= 5'd0;
    end else begin
      state_r <= state_nxt_s;
      if (!flush) begin
        case (state_r)
          S_IDLE: begin
            if (start) begin
              op_r  <= op;
              rd_r  <= rd_waddr;
              cnt_r <= {CW{1'b0}};
              if (is_div_s) begin
                acc_r     <= {{XLEN{1'b0}}, mag_a_s};
                mcand_r   <= {(2*XLEN){1'b0}};
                mplier_r  <= mag_b_s;
                neg_q_r   <= a_neg_s ^ b_neg_s;
                neg_rem_r <= a_neg_s;
              end else begin
                acc_r     <= {(2*XLEN){1'b0}};
                mcand_r   <= mcand_init_s;
                mplier_r  <= rs2_rdata;
                neg_q_r   <= 1'b0;
                neg_rem_r <= 1'b0;
              end
              if (special_s) begin
                result_r <= special_res_s;
              end else begin
                result_r <= result_r;
              end
            end else begin
              cnt_r <= cnt_r;
            end
          end
          S_CALC: begin
            acc_r <= acc_nxt_s;
            cnt_r <= cnt_r + CW'(1);
            if (!op_r[2]) begin
              mcand_r  <= {mcand_r[2*XLEN-2:0], 1'b0};
              mplier_r <= {1'b0, mplier_r[XLEN-1:1]};
            end else begin
              mplier_r <= mplier_r;
            end
            if (last_s) begin
              result_r <= final_s;
            end else begin
              result_r <= result_r;
            end
          end
          default: begin
            cnt_r <= cnt_r;
          end
        endcase
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign busy       = (state_r != S_IDLE);
  assign done       = (state_r == S_DONE) && !flush;
  assign hold_o     = !rst && (((state_r == S_IDLE) && start) || (state_r == S_CALC));
  assign result     = result_r;
  assign rd_waddr_o = rd_r;

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
Iterative RV32M multiply/divide unit in the execute stage. It consumes operands and rd address directly from the ID/EX pipeline register outputs. It holds the upstream pipeline while computing and returns a 32-bit result with a one-cycle done pulse to the execute writeback mux. Flush from the pipeline controller aborts any in-flight operation.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
flush  input  1  synchronous abort; returns to IDLE, suppresses done
start  input  1  request; sampled only in IDLE
op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_rdata  input  XLEN  operand A / dividend
rs2_rdata  input  XLEN  operand B / divisor
rd_waddr  input  5  destination register, captured with the operands
hold_o  output  1  stall request to upstream stages and to ID/EX register
busy  output  1  high in CALC or DONE
done  output  1  one-cycle pulse; result valid this cycle
result  output  XLEN  result; held until the next done
rd_waddr_o  output  5  captured destination; held until the next capture

Behaviour:
- Reset (async, rst=1): state=IDLE; done=0, busy=0, result=0, rd_waddr_o=0, counter=0. hold_o=0 while rst=1.
- States: IDLE, CALC, DONE.
- IDLE & start & !flush: latch op, operands, rd_waddr.
  - Special-case divides go to DONE directly (latency 1).
  - All other ops go to CALC with counter=0.
- CALC: one radix-2 step per cycle. After counter reaches XLEN-1, go to DONE. Normal latency is XLEN+1 cycles from the start edge to the done cycle (33 at XLEN=32).
- DONE: done=1 for exactly one cycle, result valid, then IDLE. start in the DONE cycle is ignored.
- hold_o = (IDLE & start) | CALC. It is combinational on start and deasserts in the DONE cycle, so the consumer sees done with the pipeline released.
- start outside IDLE is ignored. Operands and op are not resampled mid-operation.
- Multiply:
  - Operands extend to XLEN+1 bits: signed for MULH (both) and MULHSU (rs1 only), unsigned otherwise.
  - Shift-add into a 2*XLEN accumulator; the signed correction is applied on the MSB step.
  - MUL returns the low XLEN bits. MULH/MULHSU/MULHU return the high XLEN bits.
- Divide:
  - Restoring divide on magnitudes. For signed ops, negate inputs when negative.
  - Quotient sign = sign(A) xor sign(B). Remainder sign = sign(A).
- Special cases (1-cycle path, no CALC):
  - divisor==0: DIV/DIVU result=all ones; REM/REMU result=rs1.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF, DIV/REM): DIV=0x80000000, REM=0.
- flush:
  - flush=1 in any state: next state IDLE, done forced 0 that cycle and the next, result and rd_waddr_o unchanged.
  - flush has priority over start in the same cycle.
- rst asserted mid-operation: immediate return to the reset values above; no done.
- All arithmetic is modulo 2^XLEN on the result. No exceptions are raised.

Test Plan:
- MUL 7 x 0xFFFFFFFD (-3), start pulse -> hold_o high 33 cycles, done in cycle 33, result=0xFFFFFFEB, rd_waddr_o=captured value.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFE. MULH 0x80000000 x 0x80000000 -> result=0x40000000. MULHSU 0xFFFFFFFF x 2 -> result=0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 0x1234/0 -> done one cycle after start, result=0xFFFFFFFF. REM 0x1234/0 -> 0x1234. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same operands -> 0.
- Start DIV, assert flush in CALC cycle 10 -> IDLE next cycle, no done pulse, hold_o low. A new start two cycles later completes normally.
- Assert rst in CALC cycle 5 -> all outputs 0 immediately. Start held high during CALC/DONE -> no second operation launched until IDLE.
